s7_bin2bcd_ctrl: RTL and testbench

Sequential controller that feeds the multiplexed 7-segment display. It accepts a binary value over a valid/ready handshake and converts it to packed BCD using a serial double-dabble algorithm, one bit per cycle. It holds the last committed result stable on the output that drives the display's BCD data input, so the display never shows a partially converted value. Values above the displayable range saturate to all 9s and raise an overflow flag.

---
 rtl/s7_bin2bcd_ctrl.sv | 125 ++++++++++++
 tb/tb_s7_bin2bcd_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/s7_bin2bcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : s7_bin2bcd_ctrl
// Brief    : Binary-to-packed-BCD controller for a multiplexed 7-segment
//            display. Serial double-dabble, one input bit per cycle, with
//            saturation to all 9s and an overflow flag. The committed result
//            only changes in a single COMMIT cycle, so the display never sees
//            a partially converted value.
// Revision : 1.0 - initial release
// ============================================================================
module s7_bin2bcd_ctrl #(
  parameter int DISPLAYS_NUM = 4,
  parameter int BIN_WIDTH    = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [BIN_WIDTH-1:0]      i_bin,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
  output logic                      o_overflow,
  output logic                      o_done
);

  // Largest displayable value, 10^DISPLAYS_NUM - 1, as a 32-bit constant.
  function automatic logic [31:0] f_max_value(input int digits);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < digits; k++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

  localparam int          c_bcd_w     = DISPLAYS_NUM * 4;
  localparam logic [31:0] c_max       = f_max_value(DISPLAYS_NUM);
  localparam logic [c_bcd_w-1:0] c_all_nines = {DISPLAYS_NUM{4'h9}};
  localparam logic [4:0]  c_cnt_init  = 5'(BIN_WIDTH - 1);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_shift  = 2'd1;
  localparam logic [1:0] c_st_commit = 2'd2;

  logic [1:0]           r_state;
  logic [BIN_WIDTH-1:0] r_shift;
  logic [c_bcd_w-1:0]   r_scratch;
  logic [4:0]           r_cnt;
  logic                 r_pend_ovf;

  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_scratch_next;
  logic [BIN_WIDTH-1:0] w_shift_next;
  logic [31:0]          w_bin_ext;
  logic                 w_accept;

  assign o_ready   = (r_state == c_st_idle);
  assign w_accept  = o_ready && i_valid;
  assign w_bin_ext = {{(32 - BIN_WIDTH){1'b0}}, i_bin};

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  generate
    for (genvar g = 0; g < DISPLAYS_NUM; g++) begin : g_adj
      assign w_adj[g*4 +: 4] = (r_scratch[g*4 +: 4] >= 4'd5) ?
                               (r_scratch[g*4 +: 4] + 4'd3) :
                                r_scratch[g*4 +: 4];
    end
  endgenerate

  // Shift {scratch, shift} left by one; input MSB enters digit 0.
  assign w_scratch_next = {w_adj[c_bcd_w-2:0], r_shift[BIN_WIDTH-1]};
  assign w_shift_next   = r_shift << 1;

  // Conversion FSM and committed output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= c_st_idle;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_pend_ovf <= 1'b0;
      o_bcd_data <= '0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_shift <= i_bin;
            if (w_bin_ext > c_max) begin
              r_scratch  <= c_all_nines;
              r_pend_ovf <= 1'b1;
              r_state    <= c_st_commit;
            end else begin
              r_scratch  <= '0;
              r_pend_ovf <= 1'b0;
              r_cnt      <= c_cnt_init;
              r_state    <= c_st_shift;
            end
          end
        end
        c_st_shift: begin
          r_scratch <= w_scratch_next;
          r_shift   <= w_shift_next;
          if (r_cnt == 5'd0) begin
            r_state <= c_st_commit;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        c_st_commit: begin
          o_bcd_data <= r_scratch;
          o_overflow <= r_pend_ovf;
          o_done     <= 1'b1;
          r_state    <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s7_bin2bcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_s7_bin2bcd_ctrl
// Brief    : Directed self-checking bench for s7_bin2bcd_ctrl (defaults:
//            4 digits, 14-bit input).
// Revision : 1.0 - initial release
// ============================================================================
module tb_s7_bin2bcd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] bin = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [15:0] bcd;
  logic        ovf;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  s7_bin2bcd_ctrl #(
    .DISPLAYS_NUM(4),
    .BIN_WIDTH   (14)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_bin     (bin),
    .i_valid   (valid),
    .o_ready   (ready),
    .o_bcd_data(bcd),
    .o_overflow(ovf),
    .o_done    (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal reference, independent of the shift-and-add algorithm.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    if (v > 9999) return 16'h9999;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake one value; returns in cycle T+1.
  task automatic send(input string tag, input int v);
    chk({tag, "_ready_before"}, 32'(ready), 32'd1);
    valid = 1'b1;
    bin   = 14'(v);
    tick();
    valid = 1'b0;
    chk({tag, "_busy"}, 32'(ready), 32'd0);
  endtask

  // Called in cycle T+1; waits (bounded) for o_done and checks the result.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
    int k;
    k = 1;
    while (!done && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_done"},  32'(done),  32'd1);
    chk({tag, "_lat"},   32'(k),     32'(exp_lat));
    chk({tag, "_bcd"},   32'(bcd),   32'(exp_bcd));
    chk({tag, "_ovf"},   32'(ovf),   32'(exp_ovf));
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  int          vals[$];
  logic [15:0] expq[$];
  int          hs, dn, idx, cyc, cnt;
  logic        h;

  initial begin
    // Reset state
    #2;
    chk("rst_bcd",   32'(bcd),   32'h0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic conversion
    send("t1234", 1234);
    wait_done("t1234", 16, 16'h1234, 1'b0);
    tick();
    chk("t1234_done_pulse", 32'(done), 32'd0);
    chk("t1234_hold", 32'(bcd), 32'h1234);

    // Asynchronous reset while idle
    #2 rst = 1'b1;
    #1;
    chk("idle_rst_bcd",   32'(bcd),   32'h0);
    chk("idle_rst_ovf",   32'(ovf),   32'd0);
    chk("idle_rst_done",  32'(done),  32'd0);
    chk("idle_rst_ready", 32'(ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Upper boundary and saturation
    send("t9999", 9999);
    wait_done("t9999", 16, 16'h9999, 1'b0);
    tick();
    send("t10000", 10000);
    wait_done("t10000", 2, 16'h9999, 1'b1);
    tick();
    send("t16383", 16383);
    wait_done("t16383", 2, 16'h9999, 1'b1);
    tick();

    // Reset in SHIFT cycle 7 discards the conversion
    send("t5678", 5678);
    repeat (6) tick();
    chk("t5678_hold_bcd", 32'(bcd), 32'h9999);
    chk("t5678_hold_ovf", 32'(ovf), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("shift_rst_bcd",   32'(bcd),   32'h0);
    chk("shift_rst_ovf",   32'(ovf),   32'd0);
    chk("shift_rst_done",  32'(done),  32'd0);
    chk("shift_rst_ready", 32'(ready), 32'd1);
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) cnt++;
    end
    chk("shift_rst_no_done", 32'(cnt), 32'd0);
    chk("shift_rst_bcd_after", 32'(bcd), 32'h0);
    send("t0", 0);
    wait_done("t0", 16, 16'h0000, 1'b0);
    tick();

    // Busy inputs ignored; next value taken in the o_done cycle
    chk("t42_ready_before", 32'(ready), 32'd1);
    valid = 1'b1;
    bin   = 14'd42;
    tick();
    for (int k = 1; k < 16; k++) begin
      bin = 14'(1000 + 7 * k);
      tick();
    end
    chk("t42_done",  32'(done),  32'd1);
    chk("t42_bcd",   32'(bcd),   32'h0042);
    chk("t42_ready", 32'(ready), 32'd1);
    bin = 14'd777;
    tick();
    valid = 1'b0;
    chk("t777_done_drop", 32'(done), 32'd0);
    wait_done("t777", 16, 16'h0777, 1'b0);
    tick();
    chk("t777_done_pulse", 32'(done), 32'd0);

    // Back-to-back sweep against the decimal reference
    vals.push_back(0);
    for (int v = 37; v < 9999; v += 37) vals.push_back(v);
    vals.push_back(9999);
    hs = 0; dn = 0; idx = 0; cyc = 0;
    valid = 1'b1;
    bin   = 14'(vals[0]);
    while ((idx < vals.size() || dn < hs) && cyc < 20000) begin
      h = ready && valid;
      if (h) expq.push_back(ref_bcd(vals[idx]));
      tick();
      cyc++;
      if (done) begin
        dn++;
        if (expq.size() > 0) begin
          chk("sweep_bcd", 32'(bcd), 32'(expq.pop_front()));
          chk("sweep_ovf", 32'(ovf), 32'd0);
        end else begin
          chk("sweep_spurious_done", 32'(done), 32'd0);
        end
      end
      if (h) begin
        hs++;
        idx++;
        if (idx < vals.size()) bin = 14'(vals[idx]);
        else valid = 1'b0;
      end
    end
    chk("sweep_all_sent", 32'(idx), 32'(vals.size()));
    chk("sweep_done_count", 32'(dn), 32'(hs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
